// File: rtl/scan_resp_misr_if.sv
// scan_resp_misr_if: scan-out stream and controller status in, frame and signature results out
interface scan_resp_misr_if #(
    parameter int FF_NUM = 11,
    parameter int SIG_W = 16
);
    logic lock;
    logic shift_en;
    logic test_se;
    logic scan_done;
    logic scan_out;
    logic [19:0] scan_num;
    logic [SIG_W-1:0] sig_expect;
    logic frame_valid;
    logic [FF_NUM-1:0] frame_data;
    logic [19:0] frame_cnt;
    logic [SIG_W-1:0] signature;
    logic sig_valid;
    logic pass;
    logic fail;
    logic lock_lost;
    modport master (
        output lock, shift_en, test_se, scan_done, scan_out, scan_num, sig_expect,
        input frame_valid, frame_data, frame_cnt, signature, sig_valid, pass, fail, lock_lost
    );
    modport slave (
        input lock, shift_en, test_se, scan_done, scan_out, scan_num, sig_expect,
        output frame_valid, frame_data, frame_cnt, signature, sig_valid, pass, fail, lock_lost
    );
endinterface

// File: rtl/scan_resp_misr.sv
// scan_resp_misr: qualifies scan-out bits, frames them, compresses them into a SISR and reports pass/fail
module scan_resp_misr #(
    parameter int FF_NUM = 11,
    parameter int SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021,
    parameter logic [SIG_W-1:0] SEED = 16'hFFFF
) (
    input logic clk,
    input logic rst_n,
    scan_resp_misr_if.slave bus
);
    localparam int CW = $clog2(FF_NUM);
    localparam int DW = $clog2(FF_NUM + 4);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;
    state_t state;
    logic [SIG_W-1:0] misr;
    logic [FF_NUM-2:0] shreg;
    logic [CW-1:0] bit_cnt;
    logic [DW-1:0] drain_cnt;
    logic timeout;
    logic v;
    logic last_bit;
    logic ok;
    logic [FF_NUM-1:0] frame_nxt;
    logic [SIG_W-1:0] misr_nxt;
    assign v = bus.lock & bus.shift_en & bus.test_se;
    assign last_bit = v && bit_cnt == CW'(FF_NUM - 1);
    assign frame_nxt = {shreg, bus.scan_out};
    assign misr_nxt = {misr[SIG_W-2:0], 1'b0} ^ (misr[SIG_W-1] ? POLY : '0) ^ {{(SIG_W-1){1'b0}}, bus.scan_out};
    assign ok = misr == bus.sig_expect && bus.frame_cnt == bus.scan_num + 20'd1 && !bus.lock_lost && !timeout;
    // bit qualification, framing, compression and run sequencing; the report cycle overrides per-run state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            misr <= SEED;
            shreg <= '0;
            bit_cnt <= '0;
            drain_cnt <= '0;
            timeout <= 1'b0;
            bus.frame_valid <= 1'b0;
            bus.frame_data <= '0;
            bus.frame_cnt <= '0;
            bus.signature <= '0;
            bus.sig_valid <= 1'b0;
            bus.pass <= 1'b0;
            bus.fail <= 1'b0;
            bus.lock_lost <= 1'b0;
        end else begin
            bus.frame_valid <= 1'b0;
            bus.sig_valid <= 1'b0;
            if (v) begin
                shreg <= frame_nxt[FF_NUM-2:0];
                misr <= misr_nxt;
                bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
                if (last_bit) begin
                    bus.frame_data <= frame_nxt;
                    bus.frame_valid <= 1'b1;
                    bus.frame_cnt <= bus.frame_cnt == '1 ? bus.frame_cnt : bus.frame_cnt + 20'd1;
                end
            end else if (!bus.lock && bit_cnt != '0) begin
                bit_cnt <= '0;
                bus.lock_lost <= 1'b1;
            end
            case (state)
                IDLE: begin
                    drain_cnt <= '0;
                    state <= bus.scan_done ? DRAIN : v ? RUN : IDLE;
                end
                RUN: begin
                    drain_cnt <= '0;
                    state <= bus.scan_done ? DRAIN : RUN;
                end
                DRAIN: begin
                    if (bit_cnt == '0 && !v) begin
                        state <= REPORT;
                    end else if (drain_cnt == DW'(FF_NUM + 3)) begin
                        state <= REPORT;
                        timeout <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                REPORT: begin
                    bus.signature <= misr;
                    bus.sig_valid <= 1'b1;
                    bus.pass <= ok;
                    bus.fail <= !ok;
                    misr <= SEED;
                    bus.frame_cnt <= '0;
                    bit_cnt <= '0;
                    bus.lock_lost <= 1'b0;
                    timeout <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
